// File: rtl/proc_control_unit_pkg.sv
// proc_defs: shared opcode, ALU, branch-condition, state and IR-field definitions for the control unit.
package proc_defs;
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_B   = 3'b111;

    localparam logic [1:0] ALU_ADD_SUB = 2'b00;
    localparam logic [1:0] ALU_AND     = 2'b01;
    localparam logic [1:0] ALU_NONE    = 2'b11;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_CC = 3'b011;
    localparam logic [2:0] COND_CS = 3'b100;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int IMM_BIT = 12;
    localparam int RX_HI   = 11;
    localparam int RX_LO   = 9;
    localparam int RY_HI   = 2;
    localparam int RY_LO   = 0;

    typedef enum logic [2:0] {S_IDLE, S_F0, S_FW, S_F2, S_E3, S_E4, S_E5} state_t;

    function automatic logic is_alu(input logic [2:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_AND;
    endfunction
endpackage

// File: rtl/proc_control_unit_branch_cond_eval.sv
// branch_cond_eval: decides whether a b instruction is taken from its condition code and the flags.
module branch_cond_eval
    import proc_defs::*;
(
    input  logic [2:0] cond,
    input  logic       z_flag,
    input  logic       cout,
    output logic       taken
);
    assign taken = (cond == COND_AL) | (cond == COND_EQ & z_flag) | (cond == COND_NE & ~z_flag) |
                   (cond == COND_CC & ~cout) | (cond == COND_CS & cout);
endmodule

// File: rtl/proc_control_unit.sv
// proc_control_unit: multi-cycle fetch/decode/execute FSM driving all datapath enables.
module proc_control_unit
    import proc_defs::*;
#(
    parameter int N_REGS   = 8,
    parameter int MEM_WAIT = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [15:0]       ir,
    input  logic              z_flag,
    input  logic              cout,
    output logic              ir_in,
    output logic [N_REGS-1:0] r_in,
    output logic [N_REGS-1:0] r_out,
    output logic              imm_out,
    output logic              mem_out,
    output logic              g_out,
    output logic              a_in,
    output logic              g_in,
    output logic [1:0]        alu_op,
    output logic              add_sub_control,
    output logic              cin,
    output logic              flags_in,
    output logic              pc_incr,
    output logic              addr_in,
    output logic              dout_in,
    output logic              w_d,
    output logic              done
);
    localparam int CW = $clog2(MEM_WAIT + 1);
    localparam logic [N_REGS-1:0] ONE    = 1;
    localparam logic [N_REGS-1:0] PC_SEL = ONE << (N_REGS - 1);

    state_t state, next;
    logic [CW-1:0] cnt;
    logic taken, wait_done, op2_imm;
    logic [2:0] op, rx, ry;
    logic [N_REGS-1:0] rx_sel, ry_sel;
    logic unused_ir_bits;

    assign op             = ir[OP_HI:OP_LO];
    assign rx             = ir[RX_HI:RX_LO];
    assign ry             = ir[RY_HI:RY_LO];
    assign rx_sel         = ONE << rx;
    assign ry_sel         = ONE << ry;
    assign op2_imm        = ir[IMM_BIT] | op == OP_MVT | op == OP_B;
    assign wait_done      = cnt == CW'(MEM_WAIT - 1);
    assign unused_ir_bits = ^ir[8:3];

    branch_cond_eval u_cond (.cond(rx), .z_flag(z_flag), .cout(cout), .taken(taken));

    // the wait counter only runs while FW or ld-E4 is holding; any other move clears it
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next;
            cnt   <= (next == state && (state == S_FW || state == S_E4)) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        next            = state;
        ir_in           = 1'b0;
        r_in            = '0;
        r_out           = '0;
        imm_out         = 1'b0;
        mem_out         = 1'b0;
        g_out           = 1'b0;
        a_in            = 1'b0;
        g_in            = 1'b0;
        alu_op          = ALU_NONE;
        add_sub_control = 1'b0;
        cin             = 1'b0;
        flags_in        = 1'b0;
        pc_incr         = 1'b0;
        addr_in         = 1'b0;
        dout_in         = 1'b0;
        w_d             = 1'b0;
        done            = 1'b0;
        // while reset is held every enable stays low, so an aborted instruction cannot write
        if (resetn) begin
            case (state)
                S_IDLE: next = run ? S_F0 : S_IDLE;
                S_F0: begin
                    r_out   = PC_SEL;
                    addr_in = 1'b1;
                    pc_incr = 1'b1;
                    next    = S_FW;
                end
                S_FW: next = wait_done ? S_F2 : S_FW;
                S_F2: begin
                    ir_in = 1'b1;
                    next  = S_E3;
                end
                S_E3: begin
                    next = S_E4;
                    if (op == OP_MV || op == OP_MVT) begin
                        imm_out = op2_imm;
                        r_out   = op2_imm ? '0 : ry_sel;
                        r_in    = rx_sel;
                        done    = 1'b1;
                    end else if (is_alu(op)) begin
                        r_out = rx_sel;
                        a_in  = 1'b1;
                    end else if (op == OP_LD || op == OP_ST) begin
                        r_out   = ry_sel;
                        addr_in = 1'b1;
                    end else if (taken) begin
                        r_out = PC_SEL;
                        a_in  = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
                S_E4: begin
                    next = S_E5;
                    if (is_alu(op)) begin
                        imm_out         = op2_imm;
                        r_out           = op2_imm ? '0 : ry_sel;
                        g_in            = 1'b1;
                        flags_in        = 1'b1;
                        alu_op          = op == OP_AND ? ALU_AND : ALU_ADD_SUB;
                        add_sub_control = op == OP_SUB;
                        cin             = op == OP_SUB;
                    end else if (op == OP_LD) begin
                        next = wait_done ? S_E5 : S_E4;
                    end else if (op == OP_ST) begin
                        r_out   = rx_sel;
                        dout_in = 1'b1;
                    end else begin
                        imm_out = 1'b1;
                        g_in    = 1'b1;
                        alu_op  = ALU_ADD_SUB;
                    end
                end
                S_E5: begin
                    done    = 1'b1;
                    g_out   = is_alu(op) || op == OP_B;
                    mem_out = op == OP_LD;
                    w_d     = op == OP_ST;
                    r_in    = op == OP_B ? PC_SEL : (op == OP_ST ? '0 : rx_sel);
                end
                default: next = S_IDLE;
            endcase
            if (done) next = run ? S_F0 : S_IDLE;
        end
    end
endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit: randomized scoreboard bench; a per-instruction cycle model predicts every output each cycle.
module tb_proc_control_unit;
    localparam int MW = 1;

    logic clock = 1'b0, resetn = 1'b0, run = 1'b0, z_flag = 1'b0, cout = 1'b0;
    logic [15:0] ir = '0;
    logic ir_in, imm_out, mem_out, g_out, a_in, g_in, add_sub_control, cin, flags_in;
    logic pc_incr, addr_in, dout_in, w_d, done;
    logic [7:0] r_in, r_out;
    logic [1:0] alu_op;

    typedef struct packed {
        logic       ir_in;
        logic [7:0] r_in;
        logic [7:0] r_out;
        logic       imm_out, mem_out, g_out, a_in, g_in;
        logic [1:0] alu_op;
        logic       add_sub_control, cin, flags_in, pc_incr, addr_in, dout_in, w_d, done;
    } out_t;
    typedef out_t vq_t[$];

    out_t exp_q[$];
    out_t act, e;
    int total = 0, bad = 0, cyc_n = 0;

    proc_control_unit #(.N_REGS(8), .MEM_WAIT(MW)) dut (
        .clock(clock), .resetn(resetn), .run(run), .ir(ir), .z_flag(z_flag), .cout(cout),
        .ir_in(ir_in), .r_in(r_in), .r_out(r_out), .imm_out(imm_out), .mem_out(mem_out),
        .g_out(g_out), .a_in(a_in), .g_in(g_in), .alu_op(alu_op),
        .add_sub_control(add_sub_control), .cin(cin), .flags_in(flags_in), .pc_incr(pc_incr),
        .addr_in(addr_in), .dout_in(dout_in), .w_d(w_d), .done(done)
    );

    always #5 clock = ~clock;

    always_comb act = {ir_in, r_in, r_out, imm_out, mem_out, g_out, a_in, g_in, alu_op,
                       add_sub_control, cin, flags_in, pc_incr, addr_in, dout_in, w_d, done};

    function automatic out_t blank();
        out_t o = '0;
        o.alu_op = 2'b11;
        return o;
    endfunction

    // operand 2: immediate when the imm bit is set or for mvt/b, otherwise register rY
    function automatic out_t with_op2(input out_t o, input logic [15:0] i);
        out_t r = o;
        if (i[12] || i[15:13] == 3'd1 || i[15:13] == 3'd7) r.imm_out = 1'b1;
        else r.r_out[i[2:0]] = 1'b1;
        return r;
    endfunction

    // expected outputs of one instruction, cycle by cycle from the fetch cycle to the retiring cycle
    function automatic vq_t model(input logic [15:0] i, input bit z, input bit c);
        vq_t q;
        out_t o;
        int op = int'(i[15:13]);
        int rx = int'(i[11:9]);
        int ry = int'(i[2:0]);
        bit tk;
        tk = (rx == 0) || (rx == 1 && z) || (rx == 2 && !z) || (rx == 3 && !c) || (rx == 4 && c);
        o = blank(); o.r_out = 8'h80; o.addr_in = 1; o.pc_incr = 1; q.push_back(o);
        for (int k = 0; k < MW; k++) q.push_back(blank());
        o = blank(); o.ir_in = 1; q.push_back(o);
        if (op == 0 || op == 1) begin
            o = with_op2(blank(), i); o.r_in[rx] = 1; o.done = 1; q.push_back(o);
        end else if (op == 2 || op == 3 || op == 6) begin
            o = blank(); o.r_out[rx] = 1; o.a_in = 1; q.push_back(o);
            o = with_op2(blank(), i); o.g_in = 1; o.flags_in = 1;
            o.alu_op = op == 6 ? 2'b01 : 2'b00;
            o.add_sub_control = op == 3; o.cin = op == 3; q.push_back(o);
            o = blank(); o.g_out = 1; o.r_in[rx] = 1; o.done = 1; q.push_back(o);
        end else if (op == 4 || op == 5) begin
            o = blank(); o.r_out[ry] = 1; o.addr_in = 1; q.push_back(o);
            if (op == 4) begin
                for (int k = 0; k < MW; k++) q.push_back(blank());
                o = blank(); o.mem_out = 1; o.r_in[rx] = 1; o.done = 1; q.push_back(o);
            end else begin
                o = blank(); o.r_out[rx] = 1; o.dout_in = 1; q.push_back(o);
                o = blank(); o.w_d = 1; o.done = 1; q.push_back(o);
            end
        end else if (tk) begin
            o = blank(); o.r_out = 8'h80; o.a_in = 1; q.push_back(o);
            o = blank(); o.imm_out = 1; o.g_in = 1; o.alu_op = 2'b00; q.push_back(o);
            o = blank(); o.g_out = 1; o.r_in = 8'h80; o.done = 1; q.push_back(o);
        end else begin
            o = blank(); o.done = 1; q.push_back(o);
        end
        return q;
    endfunction

    task automatic cyc(input out_t x, input logic rn, input logic rs);
        @(posedge clock);
        #1;
        resetn = rn;
        run = rs;
        exp_q.push_back(x);
    endtask

    task automatic instr(input logic [15:0] i, input bit z, input bit c, input bit run_after, input int abort_at);
        vq_t v = model(i, z, c);
        for (int k = 0; k < v.size(); k++) begin
            if (k == abort_at) begin
                cyc(blank(), 1'b0, 1'b0);
                return;
            end
            cyc(v[k], 1'b1, k == v.size() - 1 ? run_after : 1'($urandom_range(0, 1)));
            if (k == 0) begin
                ir = i;
                z_flag = z;
                cout = c;
            end
        end
    endtask

    always @(negedge clock) begin
        cyc_n++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL outputs cycle %0d: got=%h expected=%h", cyc_n, act, e);
            end
            total++;
            if ((done && ir_in) || $countones({imm_out, mem_out, g_out, r_out}) > 1) begin
                bad++;
                $display("FAIL invariant cycle %0d: got=%h expected at most one bus source, no done with ir_in", cyc_n, act);
            end
        end
    end

    initial begin
        bit ra;
        cyc(blank(), 1'b0, 1'b0);
        cyc(blank(), 1'b0, 1'b0);
        cyc(blank(), 1'b1, 1'b0);
        cyc(blank(), 1'b1, 1'b1);
        instr(16'h1A05, 0, 0, 1, -1);
        instr(16'h6202, 0, 0, 1, -1);
        instr(16'hE20A, 1, 0, 1, -1);
        instr(16'hE20A, 0, 0, 1, -1);
        instr(16'h8604, 0, 0, 1, -1);
        instr(16'hA604, 0, 0, 0, -1);
        cyc(blank(), 1'b1, 1'b0);
        cyc(blank(), 1'b1, 1'b1);
        instr(16'h4202, 1, 1, 1, MW + 3);
        cyc(blank(), 1'b1, 1'b1);
        instr(16'h4202, 0, 1, 0, -1);
        cyc(blank(), 1'b1, 1'b1);
        for (int n = 0; n < 300; n++) begin
            ra = n == 299 ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            instr(16'($urandom), 1'($urandom), 1'($urandom), ra, -1);
            if (!ra && n != 299) begin
                repeat ($urandom_range(1, 3)) cyc(blank(), 1'b1, 1'b0);
                cyc(blank(), 1'b1, 1'b1);
            end
        end
        cyc(blank(), 1'b1, 1'b0);
        cyc(blank(), 1'b1, 1'b0);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
